// File: rtl/aud_pkg.sv
// aud_pkg: shared types and widths for the audio recorder slice.
//   AUD_DATA_W / AUD_ADDR_W : default sample and SRAM word-address widths
//   state_t                 : recorder control states
// Build option AUD_REC_STEREO_EN adds WAIT_LRC_R for the right-channel slot.
package aud_pkg;

  localparam int unsigned AUD_DATA_W = 16;
  localparam int unsigned AUD_ADDR_W = 20;

`ifdef AUD_REC_STEREO_EN
  typedef enum logic [2:0] {
    IDLE, WAIT_LRC, SKIP, SHIFT, STORE, PAUSED, WAIT_LRC_R
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WAIT_LRC, SKIP, SHIFT, STORE, PAUSED
  } state_t;
`endif

endpackage

// File: rtl/aud_recorder_if.sv
// aud_recorder_if: single-cycle SRAM write bus.
//   we   : one-cycle write strobe
//   addr : word address, valid while we=1
//   data : sample, valid while we=1
// master drives the bus (recorder), slave receives it (SRAM side).
interface aud_recorder_if
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W,
  parameter int unsigned ADDR_W = AUD_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output we, output addr, output data);
  modport slave  (input  we, input  addr, input  data);

endinterface

// File: rtl/aud_i2s_sync.sv
// aud_i2s_sync: brings the codec BCLK/ADCLRCK/ADCDAT into the i_clk domain
// and flags their edges.
//   i_clk, i_rst          : system clock, synchronous active-high reset
//   i_aud_bclk/lrc/adcdat : asynchronous codec lines
//   o_bclk_rise           : one-cycle pulse on a synchronized BCLK rise
//   o_lrc_fall/o_lrc_rise : one-cycle pulses on synchronized LRC edges
//   o_dat                 : synchronized ADCDAT, aligned with o_bclk_rise
module aud_i2s_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_aud_bclk,
  input  logic i_aud_lrc,
  input  logic i_aud_adcdat,
  output logic o_bclk_rise,
  output logic o_lrc_fall,
  output logic o_lrc_rise,
  output logic o_dat
);

  logic [SYNC_STAGES-1:0] bclk_sr, lrc_sr, dat_sr;
  logic                   bclk_prev, lrc_prev;

  // Synchronizer chains plus one extra stage for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_sr   <= '0;
      lrc_sr    <= '0;
      dat_sr    <= '0;
      bclk_prev <= 1'b0;
      lrc_prev  <= 1'b0;
    end else begin
      bclk_sr   <= {bclk_sr[SYNC_STAGES-2:0], i_aud_bclk};
      lrc_sr    <= {lrc_sr[SYNC_STAGES-2:0],  i_aud_lrc};
      dat_sr    <= {dat_sr[SYNC_STAGES-2:0],  i_aud_adcdat};
      bclk_prev <= bclk_sr[SYNC_STAGES-1];
      lrc_prev  <= lrc_sr[SYNC_STAGES-1];
    end
  end

  assign o_bclk_rise = ~bclk_prev &  bclk_sr[SYNC_STAGES-1];
  assign o_lrc_fall  =  lrc_prev  & ~lrc_sr[SYNC_STAGES-1];
  assign o_lrc_rise  = ~lrc_prev  &  lrc_sr[SYNC_STAGES-1];
  // DAT has the same chain depth as BCLK, so it is sampled at the same point.
  assign o_dat       = dat_sr[SYNC_STAGES-1];

endmodule

// File: rtl/aud_recorder.sv
// aud_recorder: I2S ADC capture into SRAM with start/pause/stop control.
//   i_clk, i_rst            : system clock, synchronous active-high reset
//   i_start/i_pause/i_stop  : control pulses (stop > pause > start)
//   i_aud_bclk/lrc/adcdat   : asynchronous WM8731 ADC I2S lines
//   sram                    : write bus (we/addr/data), one-cycle strobe
//   o_end_addr              : words written in this recording; held in IDLE
//   o_busy                  : 1 in any state except IDLE
//   o_full                  : MAX_ADDR written; sticky until next start
// Build option AUD_REC_STEREO_EN records L,R word pairs instead of left only.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned       DATA_W      = AUD_DATA_W,
  parameter int unsigned       ADDR_W      = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}},
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_bclk,
  input  logic              i_aud_lrc,
  input  logic              i_aud_adcdat,
  aud_recorder_if.master    sram,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_busy,
  output logic              o_full
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx, end_addr, end_addr_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]  bitcnt, bitcnt_nx;
  logic              full, full_nx, we, we_nx, busy, busy_nx;
  logic              bclk_rise, lrc_fall, lrc_rise, dat;
  logic              at_max, last_bit;
`ifdef AUD_REC_STEREO_EN
  logic              right, right_nx;
`else
  logic              unused_lrc_rise;
  assign unused_lrc_rise = lrc_rise;
`endif

  aud_i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_aud_bclk   (i_aud_bclk),
    .i_aud_lrc    (i_aud_lrc),
    .i_aud_adcdat (i_aud_adcdat),
    .o_bclk_rise  (bclk_rise),
    .o_lrc_fall   (lrc_fall),
    .o_lrc_rise   (lrc_rise),
    .o_dat        (dat)
  );

  assign at_max   = (addr == MAX_ADDR);
  assign last_bit = (bitcnt == CNT_W'(DATA_W - 1));

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      addr     <= '0;
      end_addr <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      full     <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
`ifdef AUD_REC_STEREO_EN
      right    <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      end_addr <= end_addr_nx;
      shreg    <= shreg_nx;
      bitcnt   <= bitcnt_nx;
      full     <= full_nx;
      we       <= we_nx;
      busy     <= busy_nx;
`ifdef AUD_REC_STEREO_EN
      right    <= right_nx;
`endif
    end
  end

  // Next state; a full store ends the recording even if a pause arrives.
  always_comb begin
    state_nx = state;
    if (state != IDLE && i_stop) begin
      state_nx = IDLE;
    end else if (state == STORE && at_max) begin
      state_nx = IDLE;
    end else if (state != IDLE && i_pause) begin
      state_nx = PAUSED;
    end else begin
      case (state)
        IDLE:       if (i_start)                state_nx = WAIT_LRC;
        WAIT_LRC:   if (lrc_fall)               state_nx = SKIP;
        SKIP:       if (bclk_rise)              state_nx = SHIFT;
        SHIFT:      if (bclk_rise && last_bit)  state_nx = STORE;
        PAUSED:     if (i_start)                state_nx = WAIT_LRC;
`ifdef AUD_REC_STEREO_EN
        WAIT_LRC_R: if (lrc_rise)               state_nx = SKIP;
        STORE:      state_nx = right ? WAIT_LRC : WAIT_LRC_R;
`else
        STORE:      state_nx = WAIT_LRC;
`endif
        default:    state_nx = IDLE;
      endcase
    end
  end

  // Datapath next values; strobe and busy are registered from state_nx so
  // they line up with the STORE cycle.
  always_comb begin
    addr_nx     = addr;
    end_addr_nx = end_addr;
    full_nx     = full;
    shreg_nx    = shreg;
    bitcnt_nx   = bitcnt;
    we_nx       = (state_nx == STORE);
    busy_nx     = (state_nx != IDLE);
`ifdef AUD_REC_STEREO_EN
    right_nx    = right;
`endif
    case (state)
      IDLE: if (i_start) begin
        addr_nx     = '0;
        end_addr_nx = '0;
        full_nx     = 1'b0;
      end
`ifdef AUD_REC_STEREO_EN
      WAIT_LRC:   if (lrc_fall) right_nx = 1'b0;
      WAIT_LRC_R: if (lrc_rise) right_nx = 1'b1;
`endif
      SKIP: if (bclk_rise) bitcnt_nx = '0;
      SHIFT: if (bclk_rise) begin
        shreg_nx  = {shreg[DATA_W-2:0], dat};
        bitcnt_nx = bitcnt + CNT_W'(1);
      end
      // The write always completes; the address saturates at MAX_ADDR.
      STORE: begin
        end_addr_nx = addr + ADDR_W'(1);
        if (at_max) full_nx = 1'b1;
        else        addr_nx = addr + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign sram.we    = we;
  assign sram.addr  = addr;
  assign sram.data  = shreg;
  assign o_end_addr = end_addr;
  assign o_busy     = busy;
  assign o_full     = full;

endmodule

// File: tb/tb_aud_recorder.sv
// tb_aud_recorder: directed I2S frames with a write scoreboard.
// Honours AUD_REC_STEREO_EN the same way as the design.
module tb_aud_recorder;

  localparam logic [19:0] MAX = 20'd3;

  logic clk = 1'b0;
  logic i_rst, i_start, i_pause, i_stop;
  logic i_aud_bclk, i_aud_lrc, i_aud_adcdat;
  logic [19:0] o_end_addr;
  logic o_busy, o_full;

  aud_recorder_if #(.DATA_W(16), .ADDR_W(20)) sram_bus ();

  aud_recorder #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(MAX), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_stop       (i_stop),
    .i_aud_bclk   (i_aud_bclk),
    .i_aud_lrc    (i_aud_lrc),
    .i_aud_adcdat (i_aud_adcdat),
    .sram         (sram_bus),
    .o_end_addr   (o_end_addr),
    .o_busy       (o_busy),
    .o_full       (o_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] sb_q[$];
  int exp_addr = 0;
  int exp_end = 0;
  bit exp_full = 1'b0;
  bit exp_busy = 1'b0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: start from IDLE clears the recording.
  task automatic model_start();
    if (!exp_busy) begin
      exp_addr = 0;
      exp_end  = 0;
      exp_full = 1'b0;
    end
    exp_busy = 1'b1;
  endtask

  task automatic expect_word(input logic [15:0] w);
    if (exp_busy) begin
      sb_q.push_back({20'(exp_addr), w});
      exp_end = exp_addr + 1;
      if (20'(exp_addr) == MAX) begin
        exp_full = 1'b1;
        exp_busy = 1'b0;
      end else begin
        exp_addr++;
      end
    end
  endtask

  task automatic expect_frame(input logic [15:0] l, input logic [15:0] r);
    expect_word(l);
`ifdef AUD_REC_STEREO_EN
    expect_word(r);
`else
    if (r == 16'hxxxx) expect_word(r);
`endif
  endtask

  // Drive {rst,stop,pause,start} for one clock; called on a negedge.
  task automatic ctl(input logic [3:0] v);
    {i_rst, i_stop, i_pause, i_start} = v;
    @(negedge clk);
    {i_rst, i_stop, i_pause, i_start} = 4'b0;
  endtask

  // One I2S frame: 18 BCLKs per slot (skip, 16 data, pad), BCLK = 8 clk.
  // Optionally fires a control pulse in the low half of left data bit ctl_at.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int ctl_at, input logic [3:0] ctl_v);
    logic [15:0] w;
    for (int ch = 0; ch < 2; ch++) begin
      w = (ch == 0) ? l : r;
      for (int k = 0; k < 18; k++) begin
        i_aud_bclk   = 1'b0;
        i_aud_lrc    = (ch != 0);
        i_aud_adcdat = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
        if (ch == 0 && k == ctl_at) begin
          ctl(ctl_v);
          if (ctl_v[3])
            chk("rst_outputs", {sram_bus.we, sram_bus.addr, sram_bus.data,
                                o_end_addr, o_busy, o_full}, 64'd0);
          repeat (3) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        i_aud_bclk = 1'b1;
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_end_addr"}, o_end_addr, 64'(exp_end));
    chk({tag, "_busy"}, o_busy, 64'(exp_busy));
    chk({tag, "_full"}, o_full, 64'(exp_full));
  endtask

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (sram_bus.we) begin
      if (prev_we) chk("we_single_cycle", 64'd1, 64'd0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 sram_bus.addr, sram_bus.data);
      end else begin
        chk("write", {sram_bus.addr, sram_bus.data}, 64'(sb_q.pop_front()));
      end
    end
    prev_we = sram_bus.we;
  end

  initial begin
    {i_rst, i_stop, i_pause, i_start} = 4'b1000;
    i_aud_bclk = 1'b0;
    i_aud_lrc = 1'b1;
    i_aud_adcdat = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sram_bus.we, sram_bus.addr, sram_bus.data,
                          o_end_addr, o_busy, o_full}, 64'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three left frames.
    ctl(4'b0001); model_start();
    expect_frame(16'hA5C3, 16'h5A3C); send_frame(16'hA5C3, 16'h5A3C, -1, 4'b0);
    expect_frame(16'h0001, 16'hFFFE); send_frame(16'h0001, 16'hFFFE, -1, 4'b0);
    expect_frame(16'h8000, 16'h7FFF); send_frame(16'h8000, 16'h7FFF, -1, 4'b0);
    chk_status("t1");
    ctl(4'b0100); exp_busy = 1'b0;
    chk_status("t1_stop");

    // Pause mid-frame, then resume.
    ctl(4'b0001); model_start();
    expect_frame(16'h1111, 16'h2222); send_frame(16'h1111, 16'h2222, -1, 4'b0);
    send_frame(16'h3333, 16'h4444, 8, 4'b0010);
    chk_status("t2_paused");
    ctl(4'b0001); model_start();
    expect_frame(16'h5555, 16'h6666); send_frame(16'h5555, 16'h6666, -1, 4'b0);
    chk_status("t2_resumed");
    ctl(4'b0100); exp_busy = 1'b0;

    // Fill to MAX_ADDR; extra frames are not written.
    ctl(4'b0001); model_start();
    for (int i = 0; i < 5; i++) begin
      expect_frame(16'hC000 + 16'(i), 16'hD000 + 16'(i));
      send_frame(16'hC000 + 16'(i), 16'hD000 + 16'(i), -1, 4'b0);
    end
    chk_status("t3_full");

    // Stop and start together while shifting.
    ctl(4'b0001); model_start();
    expect_frame(16'h0F0F, 16'hF0F0); send_frame(16'h0F0F, 16'hF0F0, -1, 4'b0);
    send_frame(16'h7777, 16'h8888, 5, 4'b0101);
    exp_busy = 1'b0;
    chk_status("t4_stop");

    // Reset mid-shift, then a fresh recording from address 0.
    ctl(4'b0001); model_start();
    send_frame(16'h9999, 16'hAAAA, 10, 4'b1000);
    exp_addr = 0; exp_end = 0; exp_full = 1'b0; exp_busy = 1'b0;
    chk_status("t5_reset");
    ctl(4'b0001); model_start();
    expect_frame(16'h1234, 16'hBEEF); send_frame(16'h1234, 16'hBEEF, -1, 4'b0);
    chk_status("t6");

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
